// File: rtl/alu_ram_pkg.sv
// Shared types for the ALU/RAM engine: opcode encoding and sequencer states.
package alu_ram_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_A = 2'd1,
        ST_RD_B = 2'd2,
        ST_EXEC = 2'd3
    } state_t;

endpackage

// File: rtl/alu_unit.sv
// Purely combinational ALU: one result word plus a carry/borrow/shift-out flag.
module alu_unit
    import alu_ram_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] res,
    output logic              carry
);

    logic [DATA_W:0] wide;

    // The top bit of the widened result carries the flag for every opcode.
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_SHL:  wide = {a, 1'b0};
            OP_SHR:  wide = {a[0], 1'b0, a[DATA_W-1:1]};
            OP_PASS: wide = {1'b0, a};
            default: wide = {1'b0, a};
        endcase
    end

    assign res   = wide[DATA_W-1:0];
    assign carry = wide[DATA_W];

endmodule

// File: rtl/alu_ram_engine.sv
// Four-cycle command engine: reads two RAM operands, runs the ALU, writes the
// result back to RAM and reports it. The host can read the RAM at any time and
// write it whenever the engine is idle.
module alu_ram_engine
    import alu_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry,
    output logic              res_zero,
    output logic [CNT_W-1:0]  op_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    alu_op_t           op_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              accept;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    alu_unit #(.DATA_W(DATA_W)) u_alu (
        .a     (opnd_a),
        .b     (opnd_b),
        .op    (op_q),
        .res   (alu_res),
        .carry (alu_carry)
    );

    // Sequencer: a fixed walk through the operand reads and the execute cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) state <= ST_RD_A;
                ST_RD_A: state <= ST_RD_B;
                ST_RD_B: state <= ST_EXEC;
                ST_EXEC: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Capture the command on acceptance so the inputs are free for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
        end else if (accept) begin
            op_q    <= alu_op_t'(cmd_op);
            src_a_q <= cmd_src_a;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
        end
    end

    // Operand fetch: A in the first read cycle, B in the second; both then hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_a <= '0;
            opnd_b <= '0;
        end else if (state == ST_RD_A) begin
            opnd_a <= mem[src_a_q];
        end else if (state == ST_RD_B) begin
            opnd_b <= mem[src_b_q];
        end
    end

    // RAM write port: result write-back in execute, host writes only when idle and out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_EXEC) begin
            mem[dst_q] <= alu_res;
        end else if (rst_n && state == ST_IDLE && host_we) begin
            mem[host_addr] <= host_din;
        end
    end

    // Host read port: registered, read-before-write, so write-backs show one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_dout <= '0;
        end else begin
            host_dout <= mem[host_addr];
        end
    end

    // Result reporting: one-cycle strobe, sticky data/flags and the completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            op_count  <= '0;
        end else begin
            res_valid <= (state == ST_EXEC);
            if (state == ST_EXEC) begin
                res_data  <= alu_res;
                res_carry <= alu_carry;
                res_zero  <= (alu_res == '0);
                op_count  <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/alu_ram_engine.md
ALU_RAM_ENGINE -- requirements
Module: alu_ram_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, ALU operand/result and RAM word width.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width; RAM depth is 2**ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 16, completed-command counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  engine can accept a command.
REQ-008 SHALL have port cmd_op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 PASS.
REQ-009 SHALL have ports cmd_src_a, cmd_src_b, cmd_dst  input  ADDR_W each  operand A, operand B, destination addresses.
REQ-010 SHALL have port host_we  input  1  host RAM write enable.
REQ-011 SHALL have port host_addr  input  ADDR_W  host RAM address.
REQ-012 SHALL have port host_din  input  DATA_W  host RAM write data.
REQ-013 SHALL have port host_dout  output  DATA_W  host RAM read data, registered.
REQ-014 SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-015 SHALL have port res_data  output  DATA_W  last result.
REQ-016 SHALL have ports res_carry, res_zero  output  1 each  last result flags.
REQ-017 SHALL have port op_count  output  CNT_W  completed-command count.

Function
REQ-018 SHALL implement FSM IDLE -> RD_A -> RD_B -> EXEC -> IDLE; cmd_ready = 1 only in IDLE.
REQ-019 SHALL accept a command on the edge where cmd_valid & cmd_ready; latch op/addresses, go RD_A.
REQ-020 SHALL, at edge E1 after acceptance, register mem[src_a]; at E2, hold A and register mem[src_b]; at E3, compute, write mem[dst], register res_*; go IDLE.
REQ-021 SHALL assert res_valid for exactly the one cycle after E3; res_data/res_carry/res_zero hold until the next result.
REQ-022 SHALL sustain one command per 4 cycles with cmd_valid held high.
REQ-023 Arithmetic: ADD {carry,res}=A+B at DATA_W+1 bits; SUB res=A-B mod 2**DATA_W, carry=1 iff A<B (borrow).
REQ-024 Logic: AND/OR/XOR/PASS(res=A) carry=0; SHL res=A<<1, carry=A[MSB]; SHR logical, carry=A[0]; B ignored for SHL/SHR/PASS.
REQ-025 SHALL set res_zero = (res == 0) for every opcode.
REQ-026 src_a, src_b, dst may be equal; operands are the values before the E3 write.
REQ-027 SHALL perform host writes only in IDLE; host_we outside IDLE is ignored with no RAM change.
REQ-028 A host write on the same edge as command acceptance SHALL complete; the command reads the new value.
REQ-029 host_dout SHALL equal mem[host_addr] one cycle after host_addr is presented, in every state, showing E3 writes from the next edge.
REQ-030 op_count SHALL increment at each E3, wrapping from 2**CNT_W-1 to 0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, cmd_ready=1, res_valid=0, res_data=0, res_carry=0, res_zero=0, host_dout=0, op_count=0.
REQ-032 Reset mid-command SHALL abort it with no write to dst and no res_valid.
REQ-033 RAM contents SHALL NOT be reset and SHALL be retained through reset.

Structure
REQ-034 Package alu_ram_pkg SHALL hold the opcode enum, FSM state enum, and opcode constants.
REQ-035 Combinational ALU SHALL be sub-module alu_unit (A, B, op -> res, carry); RAM inferred in alu_ram_engine.

Verification (DATA_W=8, ADDR_W=4)
REQ-036 host write mem[1]=0x05, mem[2]=0x03; ADD 1,2->3 -> res_valid one cycle after E3, res_data=0x08, carry=0, zero=0; host read addr 3 = 0x08; op_count=1.
REQ-037 SUB 2,1->4 -> 0xFE, carry=1; mem[5]=0xFF, mem[6]=0x01, ADD 5,6->7 -> 0x00, carry=1, zero=1.
REQ-038 mem[8]=0x81: SHL -> 0x02, carry=1; mem[9]=0x01: SHR -> 0x00, carry=1, zero=1.
REQ-039 two back-to-back commands, cmd_valid held -> second accepted exactly 4 cycles after first; host_we=1 to addr 3 while busy -> mem[3] unchanged.
REQ-040 rst_n low during RD_B -> dst unchanged, no res_valid, op_count=0, cmd_ready=1; mem[1]=0x05 still readable.
REQ-041 CNT_W=2, five commands -> op_count 1,2,3,0,1.
